fmul_issue_controller: RTL and testbench



---
 rtl/floating_point_unit_pkg.sv | 19 +
 rtl/fmul_result_buffer.sv | 56 +++++
 rtl/fmul_issue_controller.sv | 125 ++++++++++++
 tb/tb_fmul_issue_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floating_point_unit_pkg.sv
// Shared types for the FPU execution unit: float32 encoding, rounding bits and
// the multiplier's exception flags.
package floating_point_unit_pkg;

    typedef logic [31:0] float32_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fmul_exceptions_t;

endpackage

// File: rtl/fmul_result_buffer.sv
// Synchronous FIFO holding retired multiplier results until writeback takes them.
// Push and pop may coincide even when full or empty; flush empties it at the edge.
module fmul_result_buffer #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign head_o  = mem[rd_ptr];
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the head slot in the same edge, so a full buffer can still accept.
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fmul_issue_controller.sv
// Issue/retire controller for the pipelined FP multiplier: credit-based issue,
// in-flight tag tracking, result buffering, flush and protocol checking.
module fmul_issue_controller
    import floating_point_unit_pkg::*;
#(
    parameter int LATENCY      = 4,
    parameter int TAG_WIDTH    = 6,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [TAG_WIDTH-1:0] issue_tag_i,
    input  logic [31:0]          operand_a_i,
    input  logic [31:0]          operand_b_i,
    output logic                 mul_valid_o,
    output logic [31:0]          mul_multiplicand_o,
    output logic [31:0]          mul_multiplier_o,
    input  logic                 mul_valid_i,
    input  logic [31:0]          mul_result_i,
    input  logic                 mul_invalid_i,
    input  logic                 mul_overflow_i,
    input  logic                 mul_underflow_i,
    input  logic [2:0]           mul_round_bits_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [TAG_WIDTH-1:0] wb_tag_o,
    output logic [31:0]          wb_result_o,
    output logic [2:0]           wb_exceptions_o,
    output logic [2:0]           wb_round_bits_o,
    output logic                 error_o
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);

    typedef struct packed {
        logic                 valid;
        logic                 killed;
        logic [TAG_WIDTH-1:0] tag;
    } slot_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        float32_t             result;
        fmul_exceptions_t     exceptions;
        round_bits_t          round_bits;
    } wb_entry_t;

    slot_t [LATENCY-1:0] slots;
    slot_t               last;
    logic [CW-1:0]       credits;
    logic                fire;
    logic                wb_fire;
    logic                live;
    logic                push;
    logic                buf_full;
    logic                buf_empty;
    logic                protocol_err;
    wb_entry_t           push_entry;
    wb_entry_t           head;

    assign issue_ready_o      = rst_n_i & ~flush_i & (credits != '0);
    assign fire               = issue_valid_i & issue_ready_o;
    assign mul_valid_o        = fire;
    assign mul_multiplicand_o = operand_a_i;
    assign mul_multiplier_o   = operand_b_i;

    assign last    = slots[LATENCY-1];
    assign live    = last.valid & ~last.killed;
    assign push    = live & mul_valid_i & ~flush_i;
    assign wb_fire = wb_valid_o & wb_ready_i;

    // The overflow term cannot fire while credits are honoured; it guards the invariant.
    assign protocol_err = (live & ~mul_valid_i) | (mul_valid_i & ~last.valid)
                        | (push & buf_full & ~wb_fire);

    assign push_entry.tag        = last.tag;
    assign push_entry.result     = mul_result_i;
    assign push_entry.exceptions = '{invalid: mul_invalid_i, overflow: mul_overflow_i,
                                     underflow: mul_underflow_i};
    assign push_entry.round_bits = mul_round_bits_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            slots   <= '0;
            credits <= CW'(BUFFER_DEPTH);
            error_o <= 1'b0;
        end else begin
            slots[0] <= '{valid: fire, killed: 1'b0, tag: issue_tag_i};
            for (int i = 1; i < LATENCY; i++) begin
                slots[i] <= '{valid:  slots[i-1].valid,
                              killed: slots[i-1].killed | flush_i,
                              tag:    slots[i-1].tag};
            end
            // Every surviving slot is killed by a flush, so no credit stays reserved.
            if (flush_i) credits <= CW'(BUFFER_DEPTH);
            else         credits <= credits + CW'(wb_fire) - CW'(fire);
            if (protocol_err) error_o <= 1'b1;
        end
    end

    fmul_result_buffer #(
        .WIDTH($bits(wb_entry_t)),
        .DEPTH(BUFFER_DEPTH)
    ) u_result_buffer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (wb_fire),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .head_o     (head)
    );

    assign wb_valid_o      = ~buf_empty;
    assign wb_tag_o        = head.tag;
    assign wb_result_o     = head.result;
    assign wb_exceptions_o = head.exceptions;
    assign wb_round_bits_o = head.round_bits;

endmodule

// File: tb/tb_fmul_issue_controller.sv
// Self-checking bench for fmul_issue_controller with a fixed-latency multiplier model
// and an in-order writeback scoreboard.
`timescale 1ns/1ps
module tb_fmul_issue_controller;

    localparam int LATENCY      = 4;
    localparam int TAG_WIDTH    = 6;
    localparam int BUFFER_DEPTH = 8;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          res;
        logic [2:0]           exc;
        logic [2:0]           rb;
    } exp_t;

    typedef struct {
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          a;
        logic [31:0]          b;
        exp_t                 want;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, flush, issue_valid, issue_ready;
    logic [TAG_WIDTH-1:0] issue_tag;
    logic [31:0]          op_a, op_b;
    logic                 mul_valid_o;
    logic [31:0]          mul_a, mul_b;
    logic                 mul_valid_i;
    logic [31:0]          mul_result;
    logic                 mul_invalid, mul_overflow, mul_underflow;
    logic [2:0]           mul_rb;
    logic                 wb_valid, wb_ready;
    logic [TAG_WIDTH-1:0] wb_tag;
    logic [31:0]          wb_result;
    logic [2:0]           wb_exc, wb_rb;
    logic                 error;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic inject = 1'b0;

    fmul_issue_controller #(
        .LATENCY(LATENCY), .TAG_WIDTH(TAG_WIDTH), .BUFFER_DEPTH(BUFFER_DEPTH)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_tag_i(issue_tag),
        .operand_a_i(op_a), .operand_b_i(op_b),
        .mul_valid_o(mul_valid_o), .mul_multiplicand_o(mul_a), .mul_multiplier_o(mul_b),
        .mul_valid_i(mul_valid_i), .mul_result_i(mul_result),
        .mul_invalid_i(mul_invalid), .mul_overflow_i(mul_overflow),
        .mul_underflow_i(mul_underflow), .mul_round_bits_i(mul_rb),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_tag_o(wb_tag),
        .wb_result_o(wb_result), .wb_exceptions_o(wb_exc), .wb_round_bits_o(wb_rb),
        .error_o(error)
    );

    // Stand-in multiplier: exact for 2.0*3.0, otherwise an easily predicted mix of operands.
    function automatic exp_t model(input logic [TAG_WIDTH-1:0] tag, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        e.tag = tag;
        if (a == 32'h4000_0000 && b == 32'h4040_0000) begin
            e.res = 32'h40C0_0000;
            e.exc = 3'b000;
            e.rb  = 3'b000;
        end else begin
            e.res = a ^ b;
            e.exc = a[2:0];
            e.rb  = b[2:0];
        end
        return e;
    endfunction

    logic [LATENCY-1:0] pipe_v = '0;
    logic [31:0]        pipe_a [LATENCY];
    logic [31:0]        pipe_b [LATENCY];
    exp_t               resp;

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LATENCY-2:0], mul_valid_o};
        pipe_a[0] <= mul_a;
        pipe_b[0] <= mul_b;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end

    assign resp          = model('0, pipe_a[LATENCY-1], pipe_b[LATENCY-1]);
    assign mul_valid_i   = pipe_v[LATENCY-1] | inject;
    assign mul_result    = resp.res;
    assign mul_invalid   = resp.exc[2];
    assign mul_overflow  = resp.exc[1];
    assign mul_underflow = resp.exc[0];
    assign mul_rb        = resp.rb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: expectations enter on issue handshakes and leave on writeback handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_tag", wb_tag, e.tag);
                    check("sb_result", wb_result, e.res);
                    check("sb_exc", wb_exc, e.exc);
                    check("sb_rb", wb_rb, e.rb);
                end
            end
            if (flush) sb.delete();
            if (issue_valid && issue_ready) sb.push_back(model(issue_tag, op_a, op_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [TAG_WIDTH-1:0] tag, input logic [31:0] a,
                         input logic [31:0] b);
        issue_valid = 1'b1;
        issue_tag   = tag;
        op_a        = a;
        op_b        = b;
    endtask

    task automatic single_op(input vec_t v);
        int lat;
        cyc();
        drive(v.tag, v.a, v.b);
        @(negedge clk);
        check("single_issue_ready", issue_ready, 1);
        check("single_mul_valid", mul_valid_o, 1);
        check("single_mul_ops", {mul_a, mul_b}, {v.a, v.b});
        cyc();
        issue_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (wb_valid) begin
                lat = n;
                break;
            end
        end
        check("single_latency", lat, LATENCY + 1);
        check("single_tag", wb_tag, v.want.tag);
        check("single_result", wb_result, v.want.res);
        check("single_exc", wb_exc, v.want.exc);
        check("single_rb", wb_rb, v.want.rb);
    endtask

    vec_t vecs[4];
    vec_t v9;
    int   acc;
    int   seen;

    initial begin
        vecs[0] = '{tag: 6'd5,  a: 32'h4000_0000, b: 32'h4040_0000,
                    want: '{tag: 6'd5,  res: 32'h40C0_0000, exc: 3'd0, rb: 3'd0}};
        vecs[1] = '{tag: 6'd12, a: 32'h0000_00F3, b: 32'h0000_0105,
                    want: '{tag: 6'd12, res: 32'h0000_01F6, exc: 3'd3, rb: 3'd5}};
        vecs[2] = '{tag: 6'd63, a: 32'hFFFF_0007, b: 32'h0000_FFFE,
                    want: '{tag: 6'd63, res: 32'hFFFF_FFF9, exc: 3'd7, rb: 3'd6}};
        vecs[3] = '{tag: 6'd0,  a: 32'h1234_5678, b: 32'h1234_5678,
                    want: '{tag: 6'd0,  res: 32'h0000_0000, exc: 3'd0, rb: 3'd0}};
        v9      = '{tag: 6'd9,  a: 32'h0000_0011, b: 32'h0000_0022,
                    want: '{tag: 6'd9,  res: 32'h0000_0033, exc: 3'd1, rb: 3'd2}};

        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_tag = '0;
        op_a = '0; op_b = '0; wb_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_issue_ready", issue_ready, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", issue_ready, 1);
        check("post_rst_wb_valid", wb_valid, 0);
        check("post_rst_error", error, 0);
        check("post_rst_mul_valid", mul_valid_o, 0);

        // Single ops, including 2.0*3.0 with tag 5
        for (int i = 0; i < 4; i++) single_op(vecs[i]);

        // Back-to-back issue with writeback always ready
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(TAG_WIDTH'(i), $urandom, $urandom);
            @(negedge clk);
            check("b2b_ready", issue_ready, 1);
        end
        cyc();
        issue_valid = 1'b0;
        repeat (10) cyc();
        @(negedge clk);
        check("b2b_drained", sb.size(), 0);
        check("b2b_wb_idle", wb_valid, 0);

        // Backpressure: exactly BUFFER_DEPTH accepted, then one credit returned
        wb_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            drive(TAG_WIDTH'(16 + i), $urandom, $urandom);
            @(negedge clk);
            if (issue_ready) acc++;
        end
        check("bp_accepted", acc, BUFFER_DEPTH);
        cyc();
        issue_valid = 1'b0;
        repeat (LATENCY + 2) cyc();
        @(negedge clk);
        check("bp_full_ready", issue_ready, 0);
        check("bp_full_wb_valid", wb_valid, 1);
        cyc();
        drive(6'd30, $urandom, $urandom);
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp_credit_same_cycle", issue_ready, 0);
        cyc();
        wb_ready = 1'b0;
        @(negedge clk);
        check("bp_credit_next_cycle", issue_ready, 1);
        cyc();
        @(negedge clk);
        check("bp_credit_used", issue_ready, 0);
        cyc();
        issue_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (16) cyc();
        @(negedge clk);
        check("bp_drained", sb.size(), 0);

        // Flush with 2 buffered and 3 in flight
        wb_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            drive(TAG_WIDTH'(40 + i), $urandom, $urandom);
        end
        cyc();
        issue_valid = 1'b0;
        repeat (LATENCY + 2) cyc();
        for (int i = 0; i < 3; i++) begin
            drive(TAG_WIDTH'(42 + i), $urandom, $urandom);
            cyc();
        end
        issue_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready_low", issue_ready, 0);
        check("flush_wb_buffered", wb_valid, 1);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        check("flush_wb_valid", wb_valid, 0);
        check("flush_issue_ready", issue_ready, 1);
        wb_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            @(negedge clk);
            if (wb_valid) seen++;
        end
        check("flush_late_dropped", seen, 0);
        check("flush_no_error", error, 0);
        single_op(v9);

        // Spurious multiplier result with an empty tag pipe
        cyc();
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        @(negedge clk);
        check("err_set", error, 1);
        repeat (5) cyc();
        @(negedge clk);
        check("err_sticky", error, 1);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("err_cleared", error, 0);

        // Reset mid-stream with a full buffer
        wb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(TAG_WIDTH'(48 + i), $urandom, $urandom);
        end
        cyc();
        issue_valid = 1'b0;
        repeat (LATENCY + 2) cyc();
        @(negedge clk);
        check("mid_full_ready", issue_ready, 0);
        check("mid_full_wb_valid", wb_valid, 1);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", issue_ready, 0);
        cyc();
        @(negedge clk);
        check("mid_rst_wb_valid", wb_valid, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_mul_valid", mul_valid_o, 0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_back", issue_ready, 1);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            drive(TAG_WIDTH'(i), $urandom, $urandom);
            @(negedge clk);
            if (issue_ready) acc++;
        end
        check("mid_rst_credits", acc, BUFFER_DEPTH);
        cyc();
        issue_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (20) cyc();
        @(negedge clk);
        check("final_drained", sb.size(), 0);
        check("final_error", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
